// File: rtl/dds_ctrl_pkg.sv
// Shared types and constants for the DDS frequency-sweep controller.
package dds_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DWELL = 3'd2,
        ST_STEP  = 3'd3,
        ST_DONE  = 3'd4
    } sweep_state_e;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_SAW    = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell counter: counts timebase ticks and flags the tick that completes a dwell.
module dds_dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               tick_i,
    input  logic [DWELL_W-1:0] last_i,
    output logic               tc_o
);

    logic [DWELL_W-1:0] count_q;

    assign tc_o = tick_i && (count_q == last_i);

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            count_q <= '0;
        end else if (tick_i) begin
            count_q <= tc_o ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler: steps the DDS FCW between two endpoints with a
// programmable dwell, in single, sawtooth, triangle or hold mode.
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int FCW_W   = 8,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_en,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [FCW_W-1:0]   fcw_start,
    input  logic [FCW_W-1:0]   fcw_stop,
    input  logic [FCW_W-1:0]   fcw_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [FCW_W-1:0]   fcw_out,
    output logic               busy,
    output logic               dir,
    output logic               done
);

    sweep_state_e       state_q, state_d;
    logic [FCW_W-1:0]   fcw_q, fcw_d;
    logic [FCW_W-1:0]   legEnd_q, legEnd_d;
    logic               dir_q, dir_d;

    logic [1:0]         mode_q;
    logic [FCW_W-1:0]   startVal_q, stopVal_q, step_q;
    logic [DWELL_W-1:0] dwellLast_q;

    logic               cfgLoad;
    logic               dwellTc;
    logic [FCW_W-1:0]   legEndSwap;

    // Moves cur by stp toward tgt in FCW_W+1 bits so it clamps rather than wraps.
    function automatic logic [FCW_W-1:0] stepToward(
        input logic [FCW_W-1:0] cur,
        input logic [FCW_W-1:0] tgt,
        input logic [FCW_W-1:0] stp,
        input logic             down
    );
        logic [FCW_W:0]   wide;
        logic [FCW_W-1:0] res;
        if (down) begin
            wide = {1'b0, cur} - {1'b0, stp};
            res  = (wide[FCW_W] || (wide[FCW_W-1:0] <= tgt)) ? tgt : wide[FCW_W-1:0];
        end else begin
            wide = {1'b0, cur} + {1'b0, stp};
            res  = (wide >= {1'b0, tgt}) ? tgt : wide[FCW_W-1:0];
        end
        return res;
    endfunction

    assign cfgLoad    = start && !stop;
    assign legEndSwap = (legEnd_q == stopVal_q) ? startVal_q : stopVal_q;

    dds_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q != ST_DWELL),
        .tick_i (tick_en && (state_q == ST_DWELL)),
        .last_i (dwellLast_q),
        .tc_o   (dwellTc)
    );

    always_comb begin
        state_d  = state_q;
        fcw_d    = fcw_q;
        dir_d    = dir_q;
        legEnd_d = legEnd_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d  = ST_LOAD;
            fcw_d    = fcw_start;
            dir_d    = (fcw_start > fcw_stop);
            legEnd_d = fcw_stop;
        end else begin
            case (state_q)
                ST_LOAD:  state_d = ST_DWELL;
                ST_DWELL: if (dwellTc && (mode_q != MODE_HOLD)) state_d = ST_STEP;
                ST_STEP: begin
                    state_d = ST_DWELL;
                    if (fcw_q == legEnd_q) begin
                        case (mode_q)
                            MODE_SINGLE: state_d = ST_DONE;
                            MODE_SAW:    fcw_d   = startVal_q;
                            MODE_TRI: begin
                                legEnd_d = legEndSwap;
                                dir_d    = !dir_q;
                                fcw_d    = stepToward(fcw_q, legEndSwap, step_q, !dir_q);
                            end
                            default: ;
                        endcase
                    end else begin
                        fcw_d = stepToward(fcw_q, legEnd_q, step_q, dir_q);
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fcw_q       <= '0;
            dir_q       <= 1'b0;
            legEnd_q    <= '0;
            mode_q      <= MODE_SINGLE;
            startVal_q  <= '0;
            stopVal_q   <= '0;
            step_q      <= '0;
            dwellLast_q <= '0;
        end else begin
            state_q  <= state_d;
            fcw_q    <= fcw_d;
            dir_q    <= dir_d;
            legEnd_q <= legEnd_d;
            // Zero step and zero dwell both behave as one.
            if (cfgLoad) begin
                mode_q      <= mode;
                startVal_q  <= fcw_start;
                stopVal_q   <= fcw_stop;
                step_q      <= (fcw_step == '0) ? FCW_W'(1) : fcw_step;
                dwellLast_q <= (dwell == '0) ? '0 : dwell - 1'b1;
            end
        end
    end

    assign fcw_out = fcw_q;
    assign dir     = dir_q;
    assign busy    = (state_q == ST_LOAD) || (state_q == ST_DWELL) || (state_q == ST_STEP);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: records each new fcw_out value and the cycle it appeared.
module tb_dds_sweep_ctrl;
    import dds_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, tick_en, start, stop;
    logic [1:0]  mode;
    logic [7:0]  fcw_start, fcw_stop, fcw_step;
    logic [15:0] dwell;
    logic [7:0]  fcw_out;
    logic        busy, dir, done;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          doneCount = 0;
    bit          sparse = 1'b0;
    logic [7:0]  fcwLog[$];
    logic        dirLog[$];
    int          cycLog[$];

    dds_sweep_ctrl #(.FCW_W(8), .DWELL_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_en   (tick_en),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .fcw_start (fcw_start),
        .fcw_stop  (fcw_stop),
        .fcw_step  (fcw_step),
        .dwell     (dwell),
        .fcw_out   (fcw_out),
        .busy      (busy),
        .dir       (dir),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive tick_en, sample #1 after the edge, log value changes.
    task automatic stepClock();
        tick_en = sparse ? ((cyc % 4) == 3) : 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        if (fcwLog.size() == 0 || fcw_out !== fcwLog[fcwLog.size()-1]) begin
            fcwLog.push_back(fcw_out);
            dirLog.push_back(dir);
            cycLog.push_back(cyc);
        end
        if (done === 1'b1) doneCount++;
    endtask

    task automatic runCycles(input int n);
        repeat (n) stepClock();
    endtask

    task automatic runUntilDone(input int maxCyc, input string tag);
        int k = 0;
        while (done !== 1'b1 && k < maxCyc) begin
            stepClock();
            k++;
        end
        checkOutput({tag, "_done_seen"}, done, 1);
    endtask

    task automatic runUntilFcw(input logic [7:0] val, input int maxCyc, input string tag);
        int k = 0;
        while (fcw_out !== val && k < maxCyc) begin
            stepClock();
            k++;
        end
        checkOutput({tag, "_reached"}, fcw_out, val);
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] s, input logic [7:0] e,
                                 input logic [7:0] st, input logic [15:0] dw);
        mode      = m;
        fcw_start = s;
        fcw_stop  = e;
        fcw_step  = st;
        dwell     = dw;
        start     = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        start     = 1'b0;
        fcwLog.delete();
        dirLog.delete();
        cycLog.delete();
        fcwLog.push_back(fcw_out);
        dirLog.push_back(dir);
        cycLog.push_back(cyc);
        doneCount = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] triExp[8];
        logic       triDir[8];
        logic [7:0] sawExp[13];
        int         minSeen;

        triExp = '{8'd10, 8'd14, 8'd18, 8'd20, 8'd16, 8'd12, 8'd10, 8'd14};
        triDir = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 11; i++) sawExp[i] = 8'(200 - i);
        sawExp[11] = 8'd200;
        sawExp[12] = 8'd199;

        rst = 1'b1; tick_en = 1'b1; start = 1'b0; stop = 1'b0;
        mode = MODE_SINGLE; fcw_start = 8'd0; fcw_stop = 8'd0; fcw_step = 8'd0; dwell = 16'd0;
        runCycles(3);
        checkOutput("reset_fcw", fcw_out, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_dir", dir, 0);
        checkOutput("reset_done", done, 0);
        rst = 1'b0;
        runCycles(2);

        // Single ascending sweep
        applyStimulus(MODE_SINGLE, 8'd10, 8'd20, 8'd4, 16'd2);
        checkOutput("single_latency_fcw", fcw_out, 10);
        checkOutput("single_latency_busy", busy, 1);
        checkOutput("single_latency_dir", dir, 0);
        runUntilDone(100, "single");
        checkOutput("single_busy_at_done", busy, 0);
        checkOutput("single_log_len", fcwLog.size(), 4);
        if (fcwLog.size() == 4) begin
            checkOutput("single_v1", fcwLog[1], 14);
            checkOutput("single_v2", fcwLog[2], 18);
            checkOutput("single_v3", fcwLog[3], 20);
            checkOutput("single_hold_first", cycLog[1] - cycLog[0], 4);
            checkOutput("single_hold_mid", cycLog[2] - cycLog[1], 3);
        end
        runCycles(4);
        checkOutput("single_fcw_after", fcw_out, 20);
        checkOutput("single_done_count", doneCount, 1);
        checkOutput("single_busy_after", busy, 0);

        // Triangle ping-pong
        applyStimulus(MODE_TRI, 8'd10, 8'd20, 8'd4, 16'd1);
        runCycles(20);
        checkOutput("tri_log_min", fcwLog.size() >= 8, 1);
        if (fcwLog.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                checkOutput($sformatf("tri_v%0d", i), fcwLog[i], triExp[i]);
                checkOutput($sformatf("tri_dir%0d", i), dirLog[i], triDir[i]);
            end
        end
        checkOutput("tri_no_done", doneCount, 0);
        checkOutput("tri_busy", busy, 1);

        // Sawtooth descending with zero step
        applyStimulus(MODE_SAW, 8'd200, 8'd190, 8'd0, 16'd1);
        checkOutput("saw_dir", dir, 1);
        runCycles(32);
        checkOutput("saw_log_min", fcwLog.size() >= 13, 1);
        if (fcwLog.size() >= 13) begin
            for (int i = 0; i < 13; i++)
                checkOutput($sformatf("saw_v%0d", i), fcwLog[i], sawExp[i]);
        end
        minSeen = 255;
        foreach (fcwLog[i]) if (int'(fcwLog[i]) < minSeen) minSeen = int'(fcwLog[i]);
        checkOutput("saw_min", minSeen, 190);

        // Clamp at top of range, no wrap
        applyStimulus(MODE_SINGLE, 8'd250, 8'd255, 8'd10, 16'd1);
        runUntilDone(50, "clamp");
        checkOutput("clamp_log_len", fcwLog.size(), 2);
        if (fcwLog.size() == 2) checkOutput("clamp_v1", fcwLog[1], 255);

        // Sparse timebase: 3 ticks of period 4 per value
        sparse = 1'b1;
        applyStimulus(MODE_SINGLE, 8'd10, 8'd20, 8'd4, 16'd3);
        runUntilDone(300, "sparse");
        sparse = 1'b0;
        checkOutput("sparse_log_len", fcwLog.size(), 4);
        if (fcwLog.size() == 4) begin
            checkOutput("sparse_hold_14", cycLog[2] - cycLog[1], 12);
            checkOutput("sparse_hold_18", cycLog[3] - cycLog[2], 12);
        end

        // Hold mode never steps
        applyStimulus(MODE_HOLD, 8'd30, 8'd90, 8'd5, 16'd1);
        runCycles(20);
        checkOutput("hold_fcw", fcw_out, 30);
        checkOutput("hold_busy", busy, 1);
        checkOutput("hold_log_len", fcwLog.size(), 1);

        // Abort mid-sweep
        applyStimulus(MODE_SINGLE, 8'd10, 8'd20, 8'd4, 16'd2);
        runUntilFcw(8'd14, 50, "stop");
        stop = 1'b1;
        stepClock();
        stop = 1'b0;
        checkOutput("stop_busy", busy, 0);
        checkOutput("stop_fcw", fcw_out, 14);
        checkOutput("stop_done", done, 0);
        doneCount = 0;
        runCycles(5);
        checkOutput("stop_no_done", doneCount, 0);
        checkOutput("stop_fcw_frozen", fcw_out, 14);

        // start and stop together: stop wins
        start = 1'b1;
        stop  = 1'b1;
        fcw_start = 8'd77;
        stepClock();
        start = 1'b0;
        stop  = 1'b0;
        checkOutput("startstop_busy", busy, 0);
        checkOutput("startstop_fcw", fcw_out, 14);
        runCycles(3);
        checkOutput("startstop_idle", busy, 0);

        // Restart while busy
        applyStimulus(MODE_SINGLE, 8'd10, 8'd20, 8'd4, 16'd2);
        runCycles(3);
        applyStimulus(MODE_SINGLE, 8'd50, 8'd60, 8'd1, 16'd2);
        checkOutput("restart_fcw", fcw_out, 50);
        checkOutput("restart_busy", busy, 1);

        // Reset mid-sweep
        runCycles(6);
        rst = 1'b1;
        stepClock();
        rst = 1'b0;
        checkOutput("rst_fcw", fcw_out, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_dir", dir, 0);
        checkOutput("rst_done", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
